tt_sweep_checker: RTL and testbench
===================================

TT_SWEEP_CHECKER -- requirements
Module: tt_sweep_checker

Interface
REQ-001 Parameter SETTLE, default 2: cycles each vector is held before its response is sampled; legal range 1..15.
REQ-002 Parameter EXP_TABLE, default 24'hFAC688 (loopback): bits [3*i+2:3*i] are the expected {a,b,c} for vector i={x,y,z}.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 start  in  1  request one exhaustive sweep; sampled only in IDLE.
REQ-006 vec_o  out  3  drive to DUT as {x,y,z}, x is MSB.
REQ-007 resp_i  in  3  DUT response as {a,b,c}, a is MSB.
REQ-008 busy  out  1  high from the cycle after start is accepted until the cycle done is asserted.
REQ-009 done  out  1  one-cycle pulse at sweep end.
REQ-010 pass  out  1  high when the last completed sweep had zero mismatches; held until the next start.
REQ-011 err_cnt  out  4  mismatch count of the current or last sweep, range 0..8.
REQ-012 first_err_valid  out  1  at least one mismatch in the current or last sweep.
REQ-013 first_err_idx  out  3  vector index of the first mismatch; valid only when first_err_valid=1.

Function
REQ-014 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-015 IDLE: vec_o=3'b000, busy=0; start=1 -> DRIVE with idx=0 and settle count 0; clear err_cnt, pass, first_err_valid and first_err_idx on the same edge.
REQ-016 DRIVE: vec_o=idx, busy=1; settle count increments each cycle; go to SAMPLE on the cycle the count equals SETTLE-1.
REQ-017 SAMPLE: vec_o=idx; compare resp_i with EXP_TABLE entry idx.
REQ-018 On a SAMPLE mismatch, increment err_cnt; if first_err_valid=0, set first_err_valid=1 and first_err_idx=idx.
REQ-019 SAMPLE with idx<7: idx+1, settle count 0, go to DRIVE.
REQ-020 SAMPLE with idx=7: go to DONE.
REQ-021 DONE: done=1 and busy=0 for exactly one cycle; pass=(err_cnt==0) registered, including any mismatch from the final SAMPLE; go to IDLE.
REQ-022 Timing: with start accepted at edge 0, each vector takes SETTLE+1 cycles, and done is high in cycle 8*(SETTLE+1)+1 (25 for SETTLE=2).
REQ-023 start while busy or in DONE is ignored; no queuing.
REQ-024 start held high continuously gives back-to-back sweeps separated by one IDLE cycle.
REQ-025 err_cnt cannot exceed 8; no wrap logic is required, and the 4-bit width is sufficient.
REQ-026 resp_i is used only in SAMPLE; resp_i values in other states have no effect.

Reset
REQ-027 rst_n=0 at a rising edge forces IDLE, idx=0, settle count 0, vec_o=0, busy=0, done=0, pass=0, err_cnt=0, first_err_valid=0, first_err_idx=0.
REQ-028 Reset mid-sweep aborts the sweep with no done pulse; the first start after release begins a fresh sweep at idx 0.

Structure
REQ-029 Shared package sweep_pkg holds the state enum, NUM_VEC=8, VEC_W=3, RESP_W=3.
REQ-030 One sub-module, settle_timer (load, count, reach-terminal flag), implements the DRIVE hold count; all else stays in tt_sweep_checker.

Verification
REQ-031 Loopback (resp_i=vec_o), SETTLE=2, start pulse at cycle 0 -> done in cycle 25, pass=1, err_cnt=0, first_err_valid=0.
REQ-032 Loopback with resp_i forced to 3'b000 while vec_o=5 -> err_cnt=1, first_err_valid=1, first_err_idx=5, pass=0.
REQ-033 resp_i tied to 3'b111 -> err_cnt=7, first_err_idx=0, pass=0; vector 7 matches.
REQ-034 start re-pulsed at cycles 3 and 10 during a sweep -> single done at cycle 25, and no restart.
REQ-035 rst_n low for one cycle while vec_o=3 -> all outputs zero next cycle and no done; a new start then gives a full sweep with done 25 cycles later.
REQ-036 SETTLE=1, loopback -> vec_o changes every 2 cycles, done in cycle 17, pass=1.

Source files
------------

// File: rtl/tt_sweep_checker_pkg.sv
// Shared definitions for the truth-table sweep checker.
//   - state_e       : sweep FSM states
//   - NUM_VEC       : number of input vectors in one exhaustive sweep
//   - VEC_W/RESP_W  : stimulus and response widths
//   - ERR_W         : mismatch counter width (holds 0..NUM_VEC)
//   - expected_resp : selects one 3-bit entry from a packed expectation table
package sweep_pkg;

  localparam int NUM_VEC = 8;
  localparam int VEC_W   = 3;
  localparam int RESP_W  = 3;
  localparam int ERR_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Entry i of the table lives in bits [RESP_W*i +: RESP_W].
  function automatic logic [RESP_W-1:0] expected_resp(
    input logic [NUM_VEC*RESP_W-1:0] table_v,
    input logic [VEC_W-1:0]          idx
  );
    return table_v[int'(idx)*RESP_W +: RESP_W];
  endfunction

endpackage

// File: rtl/tt_sweep_checker_if.sv
// Bundle of the sweep checker's control, stimulus and result signals.
//   master : the checker (drives vec_o and all status/result signals)
//   slave  : the environment (drives start and returns resp_i)
interface tt_sweep_checker_if;
  import sweep_pkg::*;

  logic              start;
  logic [VEC_W-1:0]  vec_o;
  logic [RESP_W-1:0] resp_i;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_cnt;
  logic              first_err_valid;
  logic [VEC_W-1:0]  first_err_idx;

  modport master (
    input  start, resp_i,
    output vec_o, busy, done, pass, err_cnt, first_err_valid, first_err_idx
  );

  modport slave (
    output start, resp_i,
    input  vec_o, busy, done, pass, err_cnt, first_err_valid, first_err_idx
  );

endinterface

// File: rtl/tt_sweep_checker_settle_timer.sv
// Hold counter for the DRIVE phase: counts cycles a vector has been applied.
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : restart the count at zero (has priority over en_i)
//   en_i       : advance the count; it saturates at the terminal value
//   terminal_o : count equals SETTLE-1, i.e. the last hold cycle
module settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic terminal_o
);

  logic [3:0] cnt_q, cnt_d;

  assign terminal_o = (cnt_q == 4'(SETTLE - 1));

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && !terminal_o) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep checker. On start it drives each 3-bit vector
// {x,y,z} = 0..7 for SETTLE cycles, samples the response {a,b,c} one cycle
// later, compares it with EXP_TABLE and accumulates the result.
//   clk, rst_n             : clock, synchronous active-low reset
//   bus.start              : request a sweep (honoured only when idle)
//   bus.vec_o / bus.resp_i : stimulus to / response from the unit under check
//   bus.busy / bus.done    : sweep in progress / one-cycle end-of-sweep pulse
//   bus.pass               : last completed sweep had no mismatches
//   bus.err_cnt            : mismatches in the current or last sweep
//   bus.first_err_valid/idx: index of the first mismatching vector
module tt_sweep_checker
  import sweep_pkg::*;
#(
  parameter int                          SETTLE    = 2,
  parameter logic [NUM_VEC*RESP_W-1:0]   EXP_TABLE = 24'hFAC688
) (
  input  logic                clk,
  input  logic                rst_n,
  tt_sweep_checker_if.master  bus
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             first_err_valid_q, first_err_valid_d;
  logic [VEC_W-1:0] first_err_idx_q, first_err_idx_d;
  logic             pass_q, pass_d;

  logic timer_load, timer_en, settle_done;

  settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (timer_load),
    .en_i       (timer_en),
    .terminal_o (settle_done)
  );

  always_comb begin
    state_d           = state_q;
    idx_d             = idx_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_idx_d   = first_err_idx_q;
    pass_d            = pass_q;
    timer_load        = 1'b0;
    timer_en          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d           = ST_DRIVE;
          idx_d             = '0;
          timer_load        = 1'b1;
          err_cnt_d         = '0;
          pass_d            = 1'b0;
          first_err_valid_d = 1'b0;
          first_err_idx_d   = '0;
        end
      end
      ST_DRIVE: begin
        timer_en = 1'b1;
        if (settle_done) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (bus.resp_i != expected_resp(EXP_TABLE, idx_q)) begin
          err_cnt_d = err_cnt_q + ERR_W'(1);
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_idx_d   = idx_q;
          end
        end
        if (idx_q == VEC_W'(NUM_VEC - 1)) begin
          state_d = ST_DONE;
          // Uses the updated count so a mismatch on the last vector counts.
          pass_d  = (err_cnt_d == '0);
        end else begin
          state_d    = ST_DRIVE;
          idx_d      = idx_q + VEC_W'(1);
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q           <= ST_IDLE;
      idx_q             <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      idx_q             <= idx_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_idx_q   <= first_err_idx_d;
      pass_q            <= pass_d;
    end
  end

  logic sweeping;
  assign sweeping = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);

  assign bus.vec_o           = sweeping ? idx_q : '0;
  assign bus.busy            = sweeping;
  assign bus.done            = (state_q == ST_DONE);
  assign bus.pass            = pass_q;
  assign bus.err_cnt         = err_cnt_q;
  assign bus.first_err_valid = first_err_valid_q;
  assign bus.first_err_idx   = first_err_idx_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench for tt_sweep_checker. Stimulus pushes the expected sweep
// result when a start is accepted; a negedge monitor checks busy/vec_o during
// the sweep and the result fields when done appears. A second instance with
// SETTLE=1 checks the shorter vector period.
module tb_tt_sweep_checker;
  import sweep_pkg::*;

  localparam int SETTLE    = 2;
  localparam int VEC_CYC   = SETTLE + 1;
  localparam int SWEEP_CYC = NUM_VEC * VEC_CYC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_sweep_checker_if bus ();
  tt_sweep_checker_if bus1 ();

  tt_sweep_checker #(.SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  tt_sweep_checker #(.SETTLE(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Unit-under-check model: response looked up by the applied vector.
  logic [2:0] resp_tbl [8];
  always_comb bus.resp_i = resp_tbl[bus.vec_o];
  assign bus1.resp_i = bus1.vec_o;

  typedef struct {
    int accept;
    int done_at;
    int err_cnt;
    bit fev;
    int fei;
    bit pass;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a loopback table expects response i for vector i.
  function automatic exp_t model(input int accept);
    exp_t e;
    e.accept  = accept;
    e.done_at = accept + SWEEP_CYC;
    e.err_cnt = 0;
    e.fev     = 1'b0;
    e.fei     = 0;
    for (int v = 0; v < NUM_VEC; v++) begin
      if (resp_tbl[v] != 3'(v)) begin
        if (!e.fev) begin
          e.fev = 1'b1;
          e.fei = v;
        end
        e.err_cnt++;
      end
    end
    e.pass = (e.err_cnt == 0);
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t h;
    if (rst_n) begin
      if (sb.size() > 0) begin
        h = sb[0];
        if (cyc < h.done_at) begin
          check("busy", int'(bus.busy), 1);
          check("vec_o", int'(bus.vec_o), (cyc - h.accept) / VEC_CYC);
          check("done_early", int'(bus.done), 0);
        end else begin
          check("done_cycle", int'(bus.done), 1);
          check("busy_at_done", int'(bus.busy), 0);
          check("err_cnt", int'(bus.err_cnt), h.err_cnt);
          check("first_err_valid", int'(bus.first_err_valid), int'(h.fev));
          if (h.fev) check("first_err_idx", int'(bus.first_err_idx), h.fei);
          check("pass", int'(bus.pass), int'(h.pass));
          void'(sb.pop_front());
        end
      end else begin
        check("idle_done", int'(bus.done), 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    sb.push_back(model(cyc));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() > 0) begin
      check("sweep_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_vec_o"}, int'(bus.vec_o), 0);
    check({tag, "_busy"}, int'(bus.busy), 0);
    check({tag, "_done"}, int'(bus.done), 0);
    check({tag, "_pass"}, int'(bus.pass), 0);
    check({tag, "_err_cnt"}, int'(bus.err_cnt), 0);
    check({tag, "_fev"}, int'(bus.first_err_valid), 0);
    check({tag, "_fei"}, int'(bus.first_err_idx), 0);
  endtask

  task automatic set_loopback();
    for (int v = 0; v < NUM_VEC; v++) resp_tbl[v] = 3'(v);
  endtask

  initial begin
    int a;
    int n;
    bus.start  = 1'b0;
    bus1.start = 1'b0;
    set_loopback();
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Loopback sweep: pass, no errors, done SWEEP_CYC edges after accept.
    issue_start();
    wait_idle();
    check("pass_held", int'(bus.pass), 1);

    // Single corrupted response on vector 5.
    resp_tbl[5] = 3'b000;
    issue_start();
    wait_idle();
    check("pass_held_fail", int'(bus.pass), 0);

    // Response stuck at 3'b111: only vector 7 matches.
    for (int v = 0; v < NUM_VEC; v++) resp_tbl[v] = 3'b111;
    issue_start();
    wait_idle();

    // Start re-pulsed mid-sweep must be ignored.
    set_loopback();
    issue_start();
    repeat (2) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (6) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_idle();

    // Start held high: back-to-back sweeps with one idle cycle between.
    resp_tbl[2] = 3'b101;
    bus.start = 1'b1;
    tick();
    a = cyc;
    sb.push_back(model(a));
    while (cyc < a + SWEEP_CYC + 2) tick();
    sb.push_back(model(cyc));
    bus.start = 1'b0;
    wait_idle();

    // Reset while vector 3 is applied aborts the sweep without done.
    set_loopback();
    resp_tbl[1] = 3'b000;
    issue_start();
    n = 0;
    while (bus.vec_o != 3'd3 && n < 100) begin
      tick();
      n++;
    end
    check("reach_vec3", int'(bus.vec_o), 3);
    rst_n = 1'b0;
    sb.delete();
    tick();
    check_all_zero("abort");
    rst_n = 1'b1;
    repeat (5) tick();
    set_loopback();
    issue_start();
    wait_idle();
    check("pass_after_abort", int'(bus.pass), 1);

    // Randomised response tables with random idle gaps.
    for (int s = 0; s < 20; s++) begin
      for (int v = 0; v < NUM_VEC; v++)
        resp_tbl[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'(v);
      repeat ($urandom_range(0, 3)) tick();
      issue_start();
      wait_idle();
    end

    // SETTLE=1 instance, loopback: vector period 2, done 16 edges after accept.
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    a = cyc;
    n = 0;
    while (!bus1.done && n < 100) begin
      check("s1_busy", int'(bus1.busy), 1);
      check("s1_vec_o", int'(bus1.vec_o), (cyc - a) / 2);
      tick();
      n++;
    end
    check("s1_done_cycle", cyc - a, 16);
    check("s1_pass", int'(bus1.pass), 1);
    check("s1_err_cnt", int'(bus1.err_cnt), 0);
    check("s1_fev", int'(bus1.first_err_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
